// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: FSM state
// encoding and the default widths/timeouts used when the block is
// instantiated without overrides.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_W_UNLK,
    S_W_LOCK,
    S_SETTLE
  } pll_state_e;

  localparam int PLL_AW        = 8;
  localparam int PLL_CBW       = 16;
  localparam int PLL_UNLOCK_TO = 256;
  localparam int PLL_LOCK_TO   = 16384;
  localparam int PLL_SETTLE    = 1024;
  localparam int PLL_MAX_RETRY = 2;
  localparam int PLL_DEF_ADDR  = 0;

endpackage

// File: rtl/pll_reconf_seq_if.sv
// Request/status bus of the PLL reconfiguration sequencer.
//   REQ_VALID/REQ_ADDR : requester -> sequencer, new setting index
//   REQ_READY          : sequencer idle, request taken on VALID & READY
//   DONE               : one-cycle pulse, request applied
//   ERR                : sticky, last request failed after all retries
//   CUR_ADDR           : last successfully applied setting
interface pll_reconf_seq_if #(
  parameter int AW = 8
);
  logic          REQ_VALID;
  logic [AW-1:0] REQ_ADDR;
  logic          REQ_READY;
  logic          DONE;
  logic          ERR;
  logic [AW-1:0] CUR_ADDR;

  modport master (output REQ_VALID, REQ_ADDR,
                  input  REQ_READY, DONE, ERR, CUR_ADDR);
  modport slave  (input  REQ_VALID, REQ_ADDR,
                  output REQ_READY, DONE, ERR, CUR_ADDR);
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//   CLK  : destination clock
//   RSTX : asynchronous active-low reset, output clears to 0
//   d    : asynchronous input
//   q    : synchronised output, two CLK edges of latency
module sync2 (
  input  logic CLK,
  input  logic RSTX,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reconf_seq.sv
// Run-time PLL reprogramming sequencer. Takes a setting index, fires one
// PLL_ADDR/PLL_CHG command at the DRP controller, waits for lock to drop
// and return (with timeouts and bounded retries), and keeps HOLD high so
// downstream clock domains stay in reset until lock has been stable for
// SETTLE consecutive cycles.
//   CLK, RSTX : reference clock, asynchronous active-low reset
//   req       : request/status bus (slave side)
//   PLL_LOCK  : PLL locked, asynchronous to CLK
//   PLL_ADDR  : setting index to DRP controller
//   PLL_CHG   : one-cycle start pulse to DRP controller
//   HOLD      : reset request for downstream clock domains
module pll_reconf_seq
  import pll_ctrl_pkg::*;
#(
  parameter int            AW        = PLL_AW,
  parameter int            CBW       = PLL_CBW,
  parameter int            UNLOCK_TO = PLL_UNLOCK_TO,
  parameter int            LOCK_TO   = PLL_LOCK_TO,
  parameter int            SETTLE    = PLL_SETTLE,
  parameter int            MAX_RETRY = PLL_MAX_RETRY,
  parameter logic [AW-1:0] DEF_ADDR  = AW'(PLL_DEF_ADDR)
) (
  input  logic               CLK,
  input  logic               RSTX,
  pll_reconf_seq_if.slave    req,
  input  logic               PLL_LOCK,
  output logic [AW-1:0]      PLL_ADDR,
  output logic               PLL_CHG,
  output logic               HOLD
);
  // +2 keeps the retry counter at least one bit wide when MAX_RETRY is 0
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [CBW-1:0] UNLK_LAST   = CBW'(UNLOCK_TO - 1);
  localparam logic [CBW-1:0] LOCK_LAST   = CBW'(LOCK_TO - 1);
  localparam logic [CBW-1:0] SETTLE_LAST = CBW'(SETTLE - 1);

  pll_state_e     state, nxt;
  logic [CBW-1:0] cnt;
  logic [RW-1:0]  retry;
  logic           from_req;   // current settle belongs to a request, not power-up/recovery
  logic           lk, acc, succ, tmo;

  sync2 u_sync (.CLK(CLK), .RSTX(RSTX), .d(PLL_LOCK), .q(lk));

  assign acc = req.REQ_VALID & req.REQ_READY;

  always_comb begin
    nxt  = state;
    succ = 1'b0;
    tmo  = 1'b0;
    case (state)
      S_INIT:   if (lk) nxt = S_SETTLE;
      // an accepted request wins over a simultaneous lock drop
      S_IDLE:   if (acc) nxt = S_ISSUE; else if (!lk) nxt = S_INIT;
      S_ISSUE:  nxt = S_W_UNLK;
      S_W_UNLK: if (!lk) nxt = S_W_LOCK; else if (cnt == UNLK_LAST) tmo = 1'b1;
      S_W_LOCK: if (lk) nxt = S_SETTLE; else if (cnt == LOCK_LAST) tmo = 1'b1;
      S_SETTLE: if (!lk) nxt = S_W_LOCK;
                else if (cnt == SETTLE_LAST) begin
                  succ = 1'b1;
                  nxt  = S_IDLE;
                end
      default:  nxt = S_INIT;
    endcase
    // recovery (no request) never re-issues; it falls back to waiting for lock
    if (tmo) nxt = (from_req && (retry < RW'(MAX_RETRY))) ? S_ISSUE : S_INIT;
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state         <= S_INIT;
      cnt           <= '0;
      retry         <= '0;
      from_req      <= 1'b0;
      req.REQ_READY <= 1'b0;
      req.DONE      <= 1'b0;
      req.ERR       <= 1'b0;
      req.CUR_ADDR  <= DEF_ADDR;
      PLL_ADDR      <= DEF_ADDR;
      PLL_CHG       <= 1'b0;
      HOLD          <= 1'b1;
    end else begin
      state         <= nxt;
      cnt           <= (nxt != state) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
      req.REQ_READY <= (nxt == S_IDLE);
      HOLD          <= (nxt != S_IDLE);
      PLL_CHG       <= (nxt == S_ISSUE);
      req.DONE      <= succ & from_req;
      // PLL_ADDR doubles as the latched request address
      if (acc) begin
        PLL_ADDR <= req.REQ_ADDR;
        retry    <= '0;
        from_req <= 1'b1;
      end
      if (tmo && nxt == S_ISSUE) retry <= retry + 1'b1;
      if (succ && from_req) begin
        req.CUR_ADDR <= PLL_ADDR;
        req.ERR      <= 1'b0;
      end
      if (tmo && nxt == S_INIT && from_req) req.ERR <= 1'b1;
      if (nxt == S_INIT || succ) from_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pll_reconf_seq.sv
// Randomised scoreboard bench for pll_reconf_seq. The stimulus side
// predicts, from the block's timing rules, when each PLL_CHG pulse and each
// DONE/ERR completion must appear; a separate monitor pops and compares.
module tb_pll_reconf_seq;
  localparam int AW = 8, UNLOCK_TO = 8, LOCK_TO = 32, SETTLE = 4, MAX_RETRY = 1;
  localparam int DROP = 3, RELOCK = 10;       // PLL model timing after PLL_CHG
  localparam logic [AW-1:0] DEF = 8'h00;

  typedef enum int {M_NORM, M_STUCK, M_GLITCH} mode_e;
  typedef struct { logic [AW-1:0] addr; int cyc; } chg_t;
  typedef struct { bit is_err; logic [AW-1:0] cur; int cyc; } resp_t;

  logic          CLK = 1'b0, RSTX = 1'b0, PLL_LOCK = 1'b1;
  logic [AW-1:0] PLL_ADDR;
  logic          PLL_CHG, HOLD;

  pll_reconf_seq_if #(.AW(AW)) rif();

  pll_reconf_seq #(.AW(AW), .CBW(16), .UNLOCK_TO(UNLOCK_TO), .LOCK_TO(LOCK_TO),
                   .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY), .DEF_ADDR(DEF)) dut (
    .CLK(CLK), .RSTX(RSTX), .req(rif.slave), .PLL_LOCK(PLL_LOCK),
    .PLL_ADDR(PLL_ADDR), .PLL_CHG(PLL_CHG), .HOLD(HOLD));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int            checks = 0, errors = 0;
  chg_t          chg_q[$];
  resp_t         resp_q[$];
  logic [AW-1:0] cur_m = DEF;
  int            next_idle;   // cycle at whose edge REQ_READY is expected to rise
  mode_e         pll_mode = M_NORM;
  int            glitch_g = 2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // PLL model: lock drops DROP cycles after PLL_CHG and returns RELOCK later;
  // glitch mode adds a one-cycle low blip g cycles after relock.
  initial begin : pll_model
    mode_e m;
    int    g;
    forever begin
      @(negedge CLK);
      if (PLL_CHG === 1'b1 && pll_mode != M_STUCK) begin
        m = pll_mode;
        g = glitch_g;
        repeat (DROP) @(negedge CLK);
        PLL_LOCK = 1'b0;
        repeat (RELOCK) @(negedge CLK);
        PLL_LOCK = 1'b1;
        if (m == M_GLITCH) begin
          repeat (g) @(negedge CLK);
          PLL_LOCK = 1'b0;
          @(negedge CLK);
          PLL_LOCK = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    chg_t  c;
    resp_t r;
    logic  err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (PLL_CHG === 1'b1) begin
        if (chg_q.size() == 0) chk("unexpected_chg", PLL_CHG, 0);
        else begin
          c = chg_q.pop_front();
          chk("chg_addr", PLL_ADDR, c.addr);
          chk("chg_cycle", cyc, c.cyc);
          chk("chg_hold", HOLD, 1);
        end
      end
      if (rif.DONE === 1'b1 || (rif.ERR === 1'b1 && !err_prev)) begin
        if (resp_q.size() == 0) chk("unexpected_resp", {rif.DONE, rif.ERR}, 0);
        else begin
          r = resp_q.pop_front();
          chk("resp_err", rif.ERR, r.is_err);
          chk("resp_done", rif.DONE, !r.is_err);
          chk("resp_cycle", cyc, r.cyc);
          chk("resp_cur_addr", rif.CUR_ADDR, r.cur);
          chk("resp_hold", HOLD, r.is_err);
        end
      end
      err_prev = rif.ERR;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, rif.REQ_READY, 0);
    chk({tag, "_hold"}, HOLD, 1);
    chk({tag, "_chg"}, PLL_CHG, 0);
    chk({tag, "_done"}, rif.DONE, 0);
    chk({tag, "_err"}, rif.ERR, 0);
    chk({tag, "_cur"}, rif.CUR_ADDR, DEF);
    chk({tag, "_addr"}, PLL_ADDR, DEF);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!rif.REQ_READY && n < 200) begin @(negedge CLK); n++; end
    chk({tag, "_ready"}, rif.REQ_READY, 1);
    chk({tag, "_idle_cycle"}, cyc, next_idle);
    chk({tag, "_hold"}, HOLD, 0);
  endtask

  // Called at a negedge; raises REQ_VALID and keeps it up until accepted.
  task automatic do_req(input logic [AW-1:0] addr, input mode_e m, input int g,
                        output int a);
    int    n = 0, raise, lrise;
    chg_t  c;
    resp_t r;
    rif.REQ_VALID = 1'b1;
    rif.REQ_ADDR  = addr;
    raise = cyc;
    while (!rif.REQ_READY && n < 200) begin @(negedge CLK); n++; end
    chk("accept_ready", rif.REQ_READY, 1);
    pll_mode = m;
    glitch_g = g;
    a = cyc + 1;
    chk("accept_cycle", a, ((raise > next_idle) ? raise : next_idle) + 1);
    if (m == M_STUCK) begin
      // each attempt: one ISSUE cycle plus UNLOCK_TO cycles waiting for the drop
      for (int k = 0; k <= MAX_RETRY; k++) begin
        c.addr = addr; c.cyc = a + k * (UNLOCK_TO + 1);
        chg_q.push_back(c);
      end
      r.is_err = 1'b1; r.cur = cur_m;
      r.cyc = a + (MAX_RETRY + 1) * (UNLOCK_TO + 1);
      next_idle = r.cyc + 1 + SETTLE;   // INIT sees lock at once, then settles
    end else begin
      c.addr = addr; c.cyc = a;
      chg_q.push_back(c);
      lrise = a + DROP + RELOCK + ((m == M_GLITCH) ? g + 1 : 0);
      cur_m = addr;
      r.is_err = 1'b0; r.cur = addr;
      r.cyc = lrise + 3 + SETTLE;       // 2 sync edges + SETTLE entry + SETTLE cycles
      next_idle = r.cyc;
    end
    resp_q.push_back(r);
    @(posedge CLK);
    #1;
    rif.REQ_VALID = 1'b0;
    rif.REQ_ADDR  = AW'($urandom);
    @(negedge CLK);
  endtask

  initial begin : stim
    int    a;
    mode_e m;
    bit    last_stuck;
    rif.REQ_VALID = 1'b0;
    rif.REQ_ADDR  = '0;
    repeat (3) @(negedge CLK);
    chk_reset("rst");
    RSTX = 1'b1;
    next_idle = cyc + 3 + SETTLE;
    wait_idle("boot");

    do_req(8'h05, M_NORM, 0, a);
    do_req(AW'($urandom), M_STUCK, 0, a);
    do_req(8'h5A, M_GLITCH, 2, a);       // raised while the failed request is still busy

    last_stuck = 1'b0;
    for (int i = 0; i < 20; i++) begin
      m = mode_e'($urandom_range(0, 2));
      if (last_stuck && m == M_STUCK) m = M_NORM;
      last_stuck = (m == M_STUCK);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 30)) @(negedge CLK);
      do_req(($urandom_range(0, 3) == 0) ? cur_m : AW'($urandom), m,
             int'($urandom_range(1, 4)), a);
    end

    // asynchronous reset while waiting for relock
    do_req(8'hC3, M_NORM, 0, a);
    while (cyc < a + 10) @(negedge CLK);
    RSTX = 1'b0;
    #1;
    chk_reset("async_rst");
    resp_q.delete();
    cur_m = DEF;
    @(negedge CLK);
    RSTX = 1'b1;
    next_idle = a + DROP + RELOCK + 3 + SETTLE;
    wait_idle("reinit");
    do_req(8'h77, M_NORM, 0, a);

    for (int n = 0; n < 300 && (resp_q.size() != 0 || chg_q.size() != 0); n++)
      @(negedge CLK);
    chk("drain_resp", resp_q.size(), 0);
    chk("drain_chg", chg_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
